// File: rtl/tag_cache_pkg.sv
// Shared types and defaults for the two-requester tag cache arbiter.
package tag_cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        REFILL = 2'd2
    } state_e;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam int ADDR_W_DEF     = 32;
    localparam int REFILL_LAT_DEF = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the
// requester that was not granted last.
module rr_arb2
    import tag_cache_pkg::*;
(
    input  logic valid_a,
    input  logic valid_b,
    input  logic last_grant,
    output logic winner,
    output logic any
);

    always_comb begin
        any    = valid_a | valid_b;
        winner = REQ_A;
        if (valid_a && valid_b) begin
            winner = ~last_grant;
        end else if (valid_b) begin
            winner = REQ_B;
        end
    end

endmodule

// File: rtl/tag_cache_arb.sv
// Arbitrates two lookup requesters onto a single-outstanding tag cache port,
// stalling for a fixed refill time after each miss.
module tag_cache_arb
    import tag_cache_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int REFILL_LAT = REFILL_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req_valid,
    input  logic [ADDR_W-1:0] a_req_addr,
    output logic              a_req_ready,
    output logic              a_resp_valid,
    output logic              a_resp_hit,
    input  logic              b_req_valid,
    input  logic [ADDR_W-1:0] b_req_addr,
    output logic              b_req_ready,
    output logic              b_resp_valid,
    output logic              b_resp_hit,
    output logic              c_req_valid,
    output logic [ADDR_W-1:0] c_req_addr,
    input  logic              c_req_ready,
    input  logic              c_resp_valid,
    input  logic              c_resp_hit,
    output logic              refill_busy,
    output logic [31:0]       a_grant_count,
    output logic [31:0]       b_grant_count,
    output state_e            fsm_state
);

    localparam logic [7:0] REFILL_LOAD = (REFILL_LAT > 0) ? 8'(REFILL_LAT - 1) : 8'd0;

    state_e     state;
    logic       last_grant;
    logic       owner;
    logic [7:0] refill_cnt;
    logic       winner;
    logic       any;
    logic       accept;
    logic       resp_live;

    rr_arb2 u_rr_arb2 (
        .valid_a    (a_req_valid),
        .valid_b    (b_req_valid),
        .last_grant (last_grant),
        .winner     (winner),
        .any        (any)
    );

    // Handshake: a request moves to the cache when c_req_valid and c_req_ready
    // are both high in IDLE; only the arbitration winner sees its ready.
    // Every combinational output is forced low while rst is held.
    always_comb begin
        c_req_valid  = !rst && (state == IDLE) && any;
        c_req_addr   = '0;
        if (c_req_valid) begin
            c_req_addr = (winner == REQ_B) ? b_req_addr : a_req_addr;
        end
        accept       = c_req_valid && c_req_ready;
        a_req_ready  = accept && (winner == REQ_A);
        b_req_ready  = accept && (winner == REQ_B);
        resp_live    = !rst && (state == WAIT) && c_resp_valid;
        a_resp_valid = resp_live && (owner == REQ_A);
        b_resp_valid = resp_live && (owner == REQ_B);
        a_resp_hit   = a_resp_valid && c_resp_hit;
        b_resp_hit   = b_resp_valid && c_resp_hit;
    end

    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= REQ_B;
            owner         <= REQ_A;
            refill_cnt    <= 8'd0;
            refill_busy   <= 1'b0;
            a_grant_count <= 32'd0;
            b_grant_count <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner      <= winner;
                        last_grant <= winner;
                        if (winner == REQ_A) begin
                            a_grant_count <= a_grant_count + 32'd1;
                        end else begin
                            b_grant_count <= b_grant_count + 32'd1;
                        end
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (c_resp_valid) begin
                        if (c_resp_hit || (REFILL_LAT == 0)) begin
                            state <= IDLE;
                        end else begin
                            state       <= REFILL;
                            refill_cnt  <= REFILL_LOAD;
                            refill_busy <= 1'b1;
                        end
                    end
                end
                REFILL: begin
                    // Counter was loaded with LAT-1 so REFILL lasts LAT cycles.
                    if (refill_cnt == 8'd0) begin
                        state       <= IDLE;
                        refill_busy <= 1'b0;
                    end else begin
                        refill_cnt <= refill_cnt - 8'd1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    refill_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tag_cache_arb.sv
// Bench for tag_cache_arb: table of arbitration/response vectors plus
// hand-written reset, back-pressure and zero-latency refill sequences.
module tb_tag_cache_arb;
    import tag_cache_pkg::*;

    localparam int AW  = 32;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req_valid = 1'b0, b_req_valid = 1'b0;
    logic [AW-1:0] a_req_addr = '0, b_req_addr = '0;
    logic          c_req_ready = 1'b0, c_resp_valid = 1'b0, c_resp_hit = 1'b0;

    logic          a_req_ready, a_resp_valid, a_resp_hit;
    logic          b_req_ready, b_resp_valid, b_resp_hit;
    logic          c_req_valid, refill_busy;
    logic [AW-1:0] c_req_addr;
    logic [31:0]   a_grant_count, b_grant_count;
    state_e        fsm_state;

    logic          z_a_req_ready, z_a_resp_valid, z_a_resp_hit;
    logic          z_b_req_ready, z_b_resp_valid, z_b_resp_hit;
    logic          z_c_req_valid, z_refill_busy;
    logic [AW-1:0] z_c_req_addr;
    logic [31:0]   z_a_grant_count, z_b_grant_count;
    state_e        z_fsm_state;

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    tag_cache_arb #(.ADDR_W(AW), .REFILL_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_addr(a_req_addr), .a_req_ready(a_req_ready),
        .a_resp_valid(a_resp_valid), .a_resp_hit(a_resp_hit),
        .b_req_valid(b_req_valid), .b_req_addr(b_req_addr), .b_req_ready(b_req_ready),
        .b_resp_valid(b_resp_valid), .b_resp_hit(b_resp_hit),
        .c_req_valid(c_req_valid), .c_req_addr(c_req_addr), .c_req_ready(c_req_ready),
        .c_resp_valid(c_resp_valid), .c_resp_hit(c_resp_hit),
        .refill_busy(refill_busy), .a_grant_count(a_grant_count),
        .b_grant_count(b_grant_count), .fsm_state(fsm_state)
    );

    tag_cache_arb #(.ADDR_W(AW), .REFILL_LAT(0)) dut0 (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_addr(a_req_addr), .a_req_ready(z_a_req_ready),
        .a_resp_valid(z_a_resp_valid), .a_resp_hit(z_a_resp_hit),
        .b_req_valid(b_req_valid), .b_req_addr(b_req_addr), .b_req_ready(z_b_req_ready),
        .b_resp_valid(z_b_resp_valid), .b_resp_hit(z_b_resp_hit),
        .c_req_valid(z_c_req_valid), .c_req_addr(z_c_req_addr), .c_req_ready(c_req_ready),
        .c_resp_valid(c_resp_valid), .c_resp_hit(c_resp_hit),
        .refill_busy(z_refill_busy), .a_grant_count(z_a_grant_count),
        .b_grant_count(z_b_grant_count), .fsm_state(z_fsm_state)
    );

    typedef struct {
        logic          av;
        logic          bv;
        logic [AW-1:0] aa;
        logic [AW-1:0] ba;
        logic          hit;
        logic          exp_win;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_req_valid  = 1'b0;
        b_req_valid  = 1'b0;
        c_resp_valid = 1'b0;
        c_resp_hit   = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [1:0] e;
        a_req_valid  = v.av;
        b_req_valid  = v.bv;
        a_req_addr   = v.aa;
        b_req_addr   = v.ba;
        c_req_ready  = 1'b1;
        c_resp_valid = 1'b0;
        @(negedge clk);
        chk("accept_c_req_valid", c_req_valid, 1);
        chk("accept_c_req_addr", c_req_addr, v.exp_win ? v.ba : v.aa);
        chk("accept_a_req_ready", a_req_ready, v.exp_win == REQ_A);
        chk("accept_b_req_ready", b_req_ready, v.exp_win == REQ_B);
        chk("accept_refill_busy", refill_busy, 0);
        exp_q.push_back({v.exp_win, v.hit});
        step();
        c_resp_valid = 1'b1;
        c_resp_hit   = v.hit;
        @(negedge clk);
        chk("wait_c_req_valid", c_req_valid, 0);
        chk("wait_ready", {a_req_ready, b_req_ready}, 0);
        chk("resp_present", a_resp_valid | b_resp_valid, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("resp_a_valid", a_resp_valid, e[1] == REQ_A);
            chk("resp_b_valid", b_resp_valid, e[1] == REQ_B);
            chk("resp_hit", e[1] ? b_resp_hit : a_resp_hit, e[0]);
        end
        step();
        // Stray cache responses during REFILL must be ignored.
        if (!v.hit) begin
            for (int i = 0; i < LAT; i++) begin
                c_resp_valid = 1'b1;
                c_resp_hit   = 1'b1;
                @(negedge clk);
                chk("refill_busy", refill_busy, 1);
                chk("refill_c_req_valid", c_req_valid, 0);
                chk("refill_ready", {a_req_ready, b_req_ready}, 0);
                chk("refill_resp_valid", {a_resp_valid, b_resp_valid}, 0);
                step();
            end
            c_resp_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0000_1040, 32'h0,         1'b1, REQ_A};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'h0000_3000, 1'b1, REQ_B};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_2004, 32'h0000_3004, 1'b1, REQ_A};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_2008, 32'h0000_3008, 1'b1, REQ_B};
        vecs[4] = '{1'b0, 1'b1, 32'h0,         32'hCAFE_0100, 1'b0, REQ_B};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_2010, 32'h0000_3010, 1'b1, REQ_A};
        vecs[6] = '{1'b1, 1'b0, 32'hABCD_0000, 32'h0,         1'b0, REQ_A};
        vecs[7] = '{1'b1, 1'b1, 32'h0000_2018, 32'h0000_3018, 1'b1, REQ_B};

        // Outputs held low under reset regardless of inputs.
        rst = 1'b1;
        a_req_valid = 1'b1; b_req_valid = 1'b1;
        a_req_addr = 32'h1111_1111; b_req_addr = 32'h2222_2222;
        c_req_ready = 1'b1; c_resp_valid = 1'b1; c_resp_hit = 1'b1;
        @(negedge clk);
        chk("rst_c_req_valid", c_req_valid, 0);
        chk("rst_c_req_addr", c_req_addr, 0);
        chk("rst_ready", {a_req_ready, b_req_ready}, 0);
        chk("rst_resp", {a_resp_valid, a_resp_hit, b_resp_valid, b_resp_hit}, 0);
        chk("rst_refill_busy", refill_busy, 0);
        chk("rst_a_count", a_grant_count, 0);
        chk("rst_b_count", b_grant_count, 0);
        do_reset();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);
        clear_inputs();
        @(negedge clk);
        chk("table_a_count", a_grant_count, 4);
        chk("table_b_count", b_grant_count, 4);
        chk("table_queue_empty", exp_q.size(), 0);

        // Back-pressure from the cache holds the request without granting.
        do_reset();
        a_req_valid = 1'b1;
        a_req_addr  = 32'hDEAD_BEE0;
        c_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_a_req_ready", a_req_ready, 0);
            chk("bp_c_req_valid", c_req_valid, 1);
            chk("bp_c_req_addr", c_req_addr, 32'hDEAD_BEE0);
            step();
        end
        @(negedge clk);
        chk("bp_a_count", a_grant_count, 0);
        step();
        c_req_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", a_req_ready, 1);
        step();
        a_req_valid = 1'b0;
        c_resp_valid = 1'b1; c_resp_hit = 1'b1;
        @(negedge clk);
        chk("bp_resp_valid", a_resp_valid, 1);
        chk("bp_a_count_after", a_grant_count, 1);
        step();
        clear_inputs();

        // Reset while waiting abandons the lookup; the late response is dropped.
        do_reset();
        a_req_valid = 1'b1;
        a_req_addr  = 32'h0000_1040;
        @(negedge clk);
        chk("rw_accept", a_req_ready, 1);
        step();
        a_req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rw_count_cleared", a_grant_count, 0);
        step();
        rst = 1'b0;
        c_resp_valid = 1'b1; c_resp_hit = 1'b1;
        @(negedge clk);
        chk("rw_late_resp", {a_resp_valid, b_resp_valid}, 0);
        chk("rw_counts", {a_grant_count[15:0], b_grant_count[15:0]}, 0);
        step();
        c_resp_valid = 1'b0;
        a_req_valid  = 1'b1;
        @(negedge clk);
        chk("rw_reaccept", a_req_ready, 1);
        chk("rw_reaccept_addr", c_req_addr, 32'h0000_1040);
        step();
        a_req_valid = 1'b0;
        c_resp_valid = 1'b1; c_resp_hit = 1'b0;
        @(negedge clk);
        chk("rw_resp_valid", a_resp_valid, 1);
        chk("rw_resp_hit", a_resp_hit, 0);
        chk("rw_a_count", a_grant_count, 1);
        step();
        clear_inputs();

        // Zero refill latency: a miss returns straight to IDLE.
        do_reset();
        a_req_valid = 1'b1;
        a_req_addr  = 32'h0000_5000;
        @(negedge clk);
        chk("z_accept", z_a_req_ready, 1);
        step();
        c_resp_valid = 1'b1; c_resp_hit = 1'b0;
        @(negedge clk);
        chk("z_resp_valid", z_a_resp_valid, 1);
        chk("z_resp_hit", z_a_resp_hit, 0);
        step();
        c_resp_valid = 1'b0;
        @(negedge clk);
        chk("z_refill_busy", z_refill_busy, 0);
        chk("z_next_accept", z_a_req_ready, 1);
        chk("z_a_count", z_a_grant_count, 1);
        chk("lat4_refill_busy", refill_busy, 1);
        step();
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
